spi_slave_char_trx: RTL and testbench

//  SPI slave character transceiver: shifts one char of 1..16 bits in from MOSI and out on MISO per SPI mode.

---
 rtl/spi_slave_char_trx_if.sv | 26 ++
 rtl/spi_slave_char_trx.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_char_trx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_char_trx_if.sv
// Host-side character/config bundle for the SPI slave character transceiver.
// S_CHAR_DONE is a one-cycle valid strobe with no ready: S_RCHAR holds the char until the next strobe.
interface spi_slave_char_trx_if #(
  parameter int CHAR_NBITS = 32
);
  logic                  S_ENABLE;
  logic                  S_CPOL;
  logic                  S_CPHA;
  logic                  S_REV;
  logic [3:0]            S_CHAR_LEN;
  logic [CHAR_NBITS-1:0] S_WCHAR;
  logic [CHAR_NBITS-1:0] S_RCHAR;
  logic                  S_CHAR_DONE;
  logic                  dbg_state;
  logic                  dbg_miso_oe;

  modport master (
    output S_ENABLE, S_CPOL, S_CPHA, S_REV, S_CHAR_LEN, S_WCHAR,
    input  S_RCHAR, S_CHAR_DONE, dbg_state, dbg_miso_oe
  );

  modport slave (
    input  S_ENABLE, S_CPOL, S_CPHA, S_REV, S_CHAR_LEN, S_WCHAR,
    output S_RCHAR, S_CHAR_DONE, dbg_state, dbg_miso_oe
  );
endinterface

// File: rtl/spi_slave_char_trx.sv
// SPI slave character transceiver: oversamples CS/SCK/MOSI on S_SYSCLK and shifts
// one 1..16-bit char in on MOSI and out on MISO per CPOL/CPHA/REV.
module spi_slave_char_trx #(
  parameter int CHAR_NBITS = 32
) (
  input  logic S_SYSCLK,
  input  logic S_RESETN,
  input  logic S_SPI_CS,
  input  logic S_SPI_SCK,
  input  logic S_SPI_MOSI,
  output logic S_SPI_MISO,
  spi_slave_char_trx_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

  state_e                st_q, st_d;
  logic [2:0]            cs_sync_q, cs_sync_d;
  logic [2:0]            sck_sync_q, sck_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  rev_q, rev_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [15:0]           tx_q, tx_d;
  logic [15:0]           rx_q, rx_d;
  logic [CHAR_NBITS-1:0] rchar_q, rchar_d;
  logic                  done_q, done_d;

  logic        cs_n, cs_fall, sck_edge, lead_edge, trail_edge;
  logic        drive_edge, sample_edge, mosi_s, load;
  logic        miso_oe, miso_bit;
  logic [15:0] rx_next, len_mask;
  logic        wchar_unused;

  assign cs_sync_d   = {cs_sync_q[1:0], S_SPI_CS};
  assign sck_sync_d  = {sck_sync_q[1:0], S_SPI_SCK};
  assign mosi_sync_d = {mosi_sync_q[0], S_SPI_MOSI};

  // Stage [1] is the synchronized pin; stage [2] is its one-cycle-old copy for edge detection.
  assign cs_n        = cs_sync_q[1];
  assign cs_fall     = cs_sync_q[2] & ~cs_sync_q[1];
  assign sck_edge    = sck_sync_q[2] ^ sck_sync_q[1];
  assign lead_edge   = sck_edge & (sck_sync_q[1] != cpol_q);
  assign trail_edge  = sck_edge & (sck_sync_q[1] == cpol_q);
  assign drive_edge  = cpha_q ? lead_edge : trail_edge;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign mosi_s      = mosi_sync_q[1];

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < 16; i++) begin
      len_mask[i] = (4'(i) <= len_q);
    end
  end

  always_comb begin
    rx_next = rev_q ? {rx_q[14:0], mosi_s} : (rx_q | (16'(mosi_s) << cnt_q));
  end

  always_comb begin
    st_d    = st_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    rev_d   = rev_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rchar_d = rchar_q;
    done_d  = 1'b0;
    load    = 1'b0;

    if (!bus.S_ENABLE) begin
      st_d    = ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      tx_d    = '0;
      rx_d    = '0;
      rchar_d = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (cs_fall) begin
            st_d = ST_ACTIVE;
            load = 1'b1;
          end
        end
        ST_ACTIVE: begin
          // pend marks that a bit has been sampled, so the next drive edge advances tx.
          if (drive_edge && pend_q) begin
            tx_d   = rev_q ? (tx_q << 1) : (tx_q >> 1);
            pend_d = 1'b0;
          end
          if (sample_edge) begin
            if (cnt_q == len_q) begin
              rchar_d = CHAR_NBITS'(rx_next & len_mask);
              done_d  = 1'b1;
              load    = 1'b1;
            end else begin
              rx_d   = rx_next;
              cnt_d  = cnt_q + 4'd1;
              pend_d = 1'b1;
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase

      if (load) begin
        cpol_d = bus.S_CPOL;
        cpha_d = bus.S_CPHA;
        rev_d  = bus.S_REV;
        len_d  = bus.S_CHAR_LEN;
        tx_d   = bus.S_WCHAR[15:0];
        rx_d   = '0;
        cnt_d  = '0;
        pend_d = 1'b0;
      end

      // A completing sample in the same cycle as CS rising still reports the char.
      if (st_q == ST_ACTIVE && cs_n) begin
        st_d   = ST_IDLE;
        cnt_d  = '0;
        pend_d = 1'b0;
        rx_d   = '0;
      end
    end
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      st_q        <= ST_IDLE;
      cs_sync_q   <= 3'b111;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      rev_q       <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rchar_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      rev_q       <= rev_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rchar_q     <= rchar_d;
      done_q      <= done_d;
    end
  end

  assign miso_oe    = (st_q == ST_ACTIVE);
  assign miso_bit   = rev_q ? tx_q[len_q] : tx_q[0];
  assign S_SPI_MISO = miso_oe ? miso_bit : 1'bz;

  assign bus.S_RCHAR     = rchar_q;
  assign bus.S_CHAR_DONE = done_q;
  assign bus.dbg_state   = st_q;
  assign bus.dbg_miso_oe = miso_oe;

  assign wchar_unused = ^bus.S_WCHAR[CHAR_NBITS-1:16];

endmodule

// File: tb/tb_spi_slave_char_trx.sv
// Directed plus randomized bench for spi_slave_char_trx, driving a behavioural SPI master.
module tb_spi_slave_char_trx;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  wire  miso;

  spi_slave_char_trx_if #(.CHAR_NBITS(32)) bus ();

  spi_slave_char_trx #(.CHAR_NBITS(32)) dut (
    .S_SYSCLK   (clk),
    .S_RESETN   (rst_n),
    .S_SPI_CS   (cs),
    .S_SPI_SCK  (sck),
    .S_SPI_MOSI (mosi),
    .S_SPI_MISO (miso),
    .bus        (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wide_cnt = 0;
  int max_lat = 0;
  int last_sample_cyc = 0;
  int got_idx = 0;
  logic prev_done = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  logic        cpol_m, cpha_m, rev_m;
  logic [31:0] wchar_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects every completed char and its latency from the last sampling edge.
  always @(negedge clk) begin
    if (bus.S_CHAR_DONE === 1'b1) begin
      done_cnt <= done_cnt + 1;
      got_q.push_back(bus.S_RCHAR);
      if (prev_done) wide_cnt <= wide_cnt + 1;
      if (cyc - last_sample_cyc > max_lat) max_lat <= cyc - last_sample_cyc;
    end
    prev_done <= bus.S_CHAR_DONE;
  end

  // ---------------- reference model ----------------
  // Serialize the low n bits of w in src order, then reassemble them in dst order.
  function automatic logic [15:0] reorder(input logic [15:0] w, input int n,
                                          input bit src_msb, input bit dst_msb);
    logic [15:0] r;
    bit seq[$];
    r = '0;
    for (int k = 0; k < n; k++) seq.push_back(w[src_msb ? n - 1 - k : k]);
    for (int k = 0; k < n; k++) r[dst_msb ? n - 1 - k : k] = seq[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_mode(input logic cpol, input logic cpha, input logic rev,
                          input logic [3:0] len, input logic [31:0] wchar);
    cpol_m = cpol; cpha_m = cpha; rev_m = rev; wchar_m = wchar;
    bus.S_CPOL = cpol; bus.S_CPHA = cpha; bus.S_REV = rev;
    bus.S_CHAR_LEN = len; bus.S_WCHAR = wchar;
    sck = cpol;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_char(input int n, input logic [15:0] mword, input bit m_msb,
                          input bit cs_end, output logic [15:0] mread);
    int bi;
    mread = '0;
    for (int k = 0; k < n; k++) begin
      bi = m_msb ? n - 1 - k : k;
      if (!cpha_m) begin
        mosi = mword[bi];
        repeat (HALF) @(negedge clk);
        mread[bi] = miso; sck = ~cpol_m; last_sample_cyc = cyc;
        repeat (HALF) @(negedge clk);
        sck = cpol_m;
        if (k == n - 1 && cs_end) cs = 1'b1;
      end else begin
        repeat (HALF) @(negedge clk);
        sck = ~cpol_m; mosi = mword[bi];
        repeat (HALF) @(negedge clk);
        mread[bi] = miso; sck = cpol_m; last_sample_cyc = cyc;
        if (k == n - 1 && cs_end) cs = 1'b1;
      end
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic sck_cycles(input int nc);
    for (int k = 0; k < nc; k++) begin
      mosi = 1'($urandom);
      repeat (HALF) @(negedge clk); sck = ~cpol_m;
      repeat (HALF) @(negedge clk); sck = cpol_m;
    end
    repeat (HALF) @(negedge clk);
  endtask

  // One char with CS already low: predicts rx/tx from the model and scores it.
  task automatic do_char(input int n, input logic [15:0] mword, input bit m_msb,
                         input bit cs_end, input string tag);
    logic [15:0] mread, exp_rd;
    logic [31:0] exp_r;
    int d0;
    exp_r  = 32'(reorder(mword, n, m_msb, rev_m));
    exp_rd = reorder(wchar_m[15:0], n, rev_m, m_msb);
    exp_q.push_back(exp_r);
    d0 = done_cnt;
    spi_char(n, mword, m_msb, cs_end, mread);
    chk({tag, "_read"}, 32'(mread), 32'(exp_rd));
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_rchar"}, bus.S_RCHAR, exp_r);
    while (got_idx < got_q.size() && exp_q.size() > 0) begin
      chk({tag, "_sb"}, got_q[got_idx], exp_q.pop_front());
      got_idx++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int len;
    bit m_msb;
    int nch;

    bus.S_ENABLE = 1'b1;
    set_mode(1'b0, 1'b0, 1'b1, 4'd7, 32'h1faa5510);
    repeat (2) @(negedge clk);
    chk("rst_rchar", bus.S_RCHAR, 32'h0);
    chk("rst_done", 32'(bus.S_CHAR_DONE), 32'h0);
    chk("rst_oe", 32'(bus.dbg_miso_oe), 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0, MSB first, 8 bits; first MISO bit valid within 3 cycles of CS fall.
    cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("m0_oe", 32'(bus.dbg_miso_oe), 32'h1);
    chk("m0_first_bit", 32'(miso), 32'(wchar_m[7]));
    do_char(8, 16'h0001, 1'b1, 1'b0, "m0");
    chk("m0_const_rchar", bus.S_RCHAR, 32'h1);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    chk("m0_deselect_oe", 32'(bus.dbg_miso_oe), 32'h0);

    // LSB first.
    set_mode(1'b0, 1'b0, 1'b0, 4'd7, 32'h1faa5510);
    cs = 1'b0; repeat (4) @(negedge clk);
    do_char(8, 16'h0001, 1'b0, 1'b0, "rev0");
    cs = 1'b1; repeat (6) @(negedge clk);

    // Mode 3, 16 bits.
    set_mode(1'b1, 1'b1, 1'b1, 4'd15, 32'h1faa5510);
    cs = 1'b0; repeat (4) @(negedge clk);
    do_char(16, 16'hA5C3, 1'b1, 1'b0, "m3");
    chk("m3_const_rchar", bus.S_RCHAR, 32'h0000A5C3);
    cs = 1'b1; repeat (6) @(negedge clk);

    // Three back-to-back chars under one CS.
    set_mode(1'b0, 1'b0, 1'b1, 4'd7, 32'h1faa5510);
    d0 = done_cnt;
    cs = 1'b0; repeat (4) @(negedge clk);
    do_char(8, 16'h0001, 1'b1, 1'b0, "b2b1");
    do_char(8, 16'h0002, 1'b1, 1'b0, "b2b2");
    do_char(8, 16'h0003, 1'b1, 1'b0, "b2b3");
    cs = 1'b1; repeat (6) @(negedge clk);
    chk("b2b_count", 32'(done_cnt - d0), 32'd3);

    // Abort after 4 SCK cycles, then a clean char.
    d0 = done_cnt;
    cs = 1'b0; repeat (4) @(negedge clk);
    sck_cycles(4);
    cs = 1'b1; repeat (6) @(negedge clk);
    chk("abort_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_rchar", bus.S_RCHAR, 32'h3);
    chk("abort_oe", 32'(bus.dbg_miso_oe), 32'h0);
    cs = 1'b0; repeat (4) @(negedge clk);
    do_char(8, 16'h005A, 1'b1, 1'b0, "post_abort");
    cs = 1'b1; repeat (6) @(negedge clk);

    // CS rises in the same cycle as the final sample: char still completes.
    set_mode(1'b0, 1'b1, 1'b1, 4'd7, 32'h000000C7);
    cs = 1'b0; repeat (4) @(negedge clk);
    do_char(8, 16'h00B4, 1'b1, 1'b1, "cs_last");
    repeat (6) @(negedge clk);
    chk("cs_last_oe", 32'(bus.dbg_miso_oe), 32'h0);

    // Disabled block ignores full traffic.
    bus.S_ENABLE = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_rchar", bus.S_RCHAR, 32'h0);
    d0 = done_cnt;
    cs = 1'b0; repeat (4) @(negedge clk);
    chk("dis_oe", 32'(bus.dbg_miso_oe), 32'h0);
    sck_cycles(8);
    cs = 1'b1; repeat (6) @(negedge clk);
    chk("dis_done", 32'(done_cnt - d0), 32'd0);
    bus.S_ENABLE = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in the middle of a char.
    set_mode(1'b0, 1'b0, 1'b1, 4'd7, 32'h00000081);
    cs = 1'b0; repeat (4) @(negedge clk);
    do_char(8, 16'h003C, 1'b1, 1'b0, "pre_rst");
    sck_cycles(3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rchar", bus.S_RCHAR, 32'h0);
    chk("midrst_done", 32'(bus.S_CHAR_DONE), 32'h0);
    chk("midrst_oe", 32'(bus.dbg_miso_oe), 32'h0);
    chk("midrst_state", 32'(bus.dbg_state), 32'h0);
    cs = 1'b1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Randomized frames: random mode, length, order and data.
    for (int f = 0; f < 14; f++) begin
      len = (f == 0) ? 0 : (f == 1) ? 15 : int'($urandom_range(0, 15));
      set_mode(1'($urandom), 1'($urandom), 1'($urandom), 4'(len), $urandom);
      m_msb = 1'($urandom);
      nch = int'($urandom_range(1, 3));
      cs = 1'b0; repeat (4) @(negedge clk);
      for (int c = 0; c < nch; c++) begin
        do_char(len + 1, 16'($urandom), m_msb, 1'b0, "rnd");
      end
      cs = 1'b1; repeat (6) @(negedge clk);
    end

    // ---------------- final report ----------------
    chk("done_latency_le4", 32'(max_lat <= 4), 32'd1);
    chk("done_pulse_width", 32'(wide_cnt), 32'd0);
    chk("sb_exp_left", 32'(exp_q.size()), 32'd0);
    chk("sb_got_left", 32'(got_q.size() - got_idx), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
